// File: rtl/q_argmax_scanner_pkg.sv
// Shared encodings and default geometry for the Q-table read path
// (scanner, mux4to1/mux8to1 and Q-table blocks).
package q_argmax_scanner_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_ACTION   = 4;
  localparam int DEF_SEL_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/q_argmax_scanner_compare.sv
// Signed strict compare: take_new when cand beats best (greater for argmax,
// less for argmin). Ties never win, so the lower index is kept.
module q_compare_update
  import q_argmax_scanner_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] cand,
  input  logic signed [DATA_WIDTH-1:0] best,
  input  logic                         find_min,
  output logic                         take_new
);

  assign take_new = find_min ? (cand < best) : (cand > best);

endmodule

// File: rtl/q_argmax_scanner.sv
// Steps the external mux select over all actions and reports the arg-max
// (or arg-min) Q-value and its index.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | sel parked at 0, waiting for start
//   ST_SCAN | one action per cycle, running best updated from q_in
//   ST_DONE | one-cycle done pulse, results already in q_best/act_best
module q_argmax_scanner
  import q_argmax_scanner_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_ACTION   = DEF_N_ACTION,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         find_min,
  output logic [SEL_WIDTH-1:0]         sel,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] q_best,
  output logic [SEL_WIDTH-1:0]         act_best
);

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(N_ACTION - 1);

  state_t                         state;
  logic                           find_min_q;
  logic signed [DATA_WIDTH-1:0]   run_best;
  logic [SEL_WIDTH-1:0]           run_idx;
  logic                           cmp_take;
  logic                           take_new;
  logic signed [DATA_WIDTH-1:0]   next_best;
  logic [SEL_WIDTH-1:0]           next_idx;

  q_compare_update #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .cand     (q_in),
    .best     (run_best),
    .find_min (find_min_q),
    .take_new (cmp_take)
  );

  // The first action loads unconditionally, so stale running state never leaks in.
  assign take_new  = (sel == '0) || cmp_take;
  assign next_best = take_new ? q_in : run_best;
  assign next_idx  = take_new ? sel  : run_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      q_best     <= '0;
      act_best   <= '0;
      find_min_q <= 1'b0;
      run_best   <= '0;
      run_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sel  <= '0;
          busy <= 1'b0;
          if (start) begin
            find_min_q <= find_min;
            busy       <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          run_best <= next_best;
          run_idx  <= next_idx;
          if (sel == LAST_SEL) begin
            q_best   <= next_best;
            act_best <= next_idx;
            sel      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            sel <= sel + SEL_WIDTH'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_argmax_scanner.sv
// Bench for q_argmax_scanner: 4-action and 8-action instances fed by modelled
// muxes, directed and random scans checked against an extremum model.
module tb_q_argmax_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start4 = 1'b0, fm4 = 1'b0, start8 = 1'b0, fm8 = 1'b0;
  logic [1:0] sel4, act4;
  logic [2:0] sel8, act8;
  logic busy4, done4, busy8, done8;
  logic signed [15:0] q_in4, q_in8, q_best4, q_best8;
  logic signed [15:0] mem4 [4];
  logic signed [15:0] mem8 [8];

  assign q_in4 = mem4[sel4];
  assign q_in8 = mem8[sel8];

  q_argmax_scanner #(.DATA_WIDTH(16), .N_ACTION(4), .SEL_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .find_min(fm4), .sel(sel4),
    .q_in(q_in4), .busy(busy4), .done(done4), .q_best(q_best4), .act_best(act4)
  );

  q_argmax_scanner #(.DATA_WIDTH(16), .N_ACTION(8), .SEL_WIDTH(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .find_min(fm8), .sel(sel8),
    .q_in(q_in8), .busy(busy8), .done(done8), .q_best(q_best8), .act_best(act8)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic signed [15:0] prev_q [2] = '{16'sd0, 16'sd0};
  int                 prev_a [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic f);
    if (w == 8) begin start8 = s; fm8 = f; end
    else begin start4 = s; fm4 = f; end
  endtask

  // Extremum first, then the lowest index holding it.
  function automatic void ref_model(input logic signed [15:0] v[$], input bit fm,
                                    output logic signed [15:0] best, output int idx);
    best = v[0];
    foreach (v[i]) if (fm ? (v[i] < best) : (v[i] > best)) best = v[i];
    idx = 0;
    for (int i = v.size() - 1; i >= 0; i--) if (v[i] == best) idx = i;
  endfunction

  // Starts in the current (idle) cycle T; returns in cycle T+n+2.
  task automatic scan(input int w, input logic signed [15:0] v[$], input bit fm, input bit noisy);
    int n = (w == 8) ? 8 : 4;
    int k = (w == 8) ? 1 : 0;
    logic signed [15:0] eq;
    int ea;
    ref_model(v, fm, eq, ea);
    for (int i = 0; i < n; i++) if (w == 8) mem8[i] = v[i]; else mem4[i] = v[i];
    drive(w, 1'b1, fm);
    for (int c = 1; c <= n; c++) begin
      tick();
      if (noisy) drive(w, 1'b1, ~fm); else drive(w, 1'b0, fm);
      check($sformatf("w%0d sel c%0d", w, c), (w == 8) ? sel8 : {1'b0, sel4}, c - 1);
      check($sformatf("w%0d busy c%0d", w, c), (w == 8) ? busy8 : busy4, 1);
      check($sformatf("w%0d done_lo c%0d", w, c), (w == 8) ? done8 : done4, 0);
      check($sformatf("w%0d q_hold c%0d", w, c), (w == 8) ? q_best8 : q_best4, prev_q[k]);
    end
    tick();
    check($sformatf("w%0d done", w), (w == 8) ? done8 : done4, 1);
    check($sformatf("w%0d busy_done", w), (w == 8) ? busy8 : busy4, 0);
    check($sformatf("w%0d sel_done", w), (w == 8) ? sel8 : {1'b0, sel4}, 0);
    check($sformatf("w%0d q_best", w), (w == 8) ? q_best8 : q_best4, eq);
    check($sformatf("w%0d act_best", w), (w == 8) ? act8 : {1'b0, act4}, ea);
    tick();
    drive(w, 1'b0, fm);
    check($sformatf("w%0d done_pulse", w), (w == 8) ? done8 : done4, 0);
    check($sformatf("w%0d idle_busy", w), (w == 8) ? busy8 : busy4, 0);
    check($sformatf("w%0d q_keep", w), (w == 8) ? q_best8 : q_best4, eq);
    prev_q[k] = eq;
    prev_a[k] = ea;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] v[$];
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mem4[i] = '0;
    for (int i = 0; i < 8; i++) mem8[i] = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst sel4", sel4, 0);       check("rst busy4", busy4, 0);
    check("rst done4", done4, 0);     check("rst q4", q_best4, 0);
    check("rst act4", act4, 0);       check("rst sel8", sel8, 0);
    check("rst busy8", busy8, 0);     check("rst q8", q_best8, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    v = {16'sd10, -16'sd3, 16'sd250, 16'sd7};
    scan(4, v, 1'b0, 1'b0);
    scan(4, v, 1'b1, 1'b0);
    v = {16'sd5, 16'sd9, 16'sd9, 16'sd9};
    scan(4, v, 1'b0, 1'b0);
    v = {16'sh8000, 16'sh8000, 16'sd0, 16'sd1};
    scan(4, v, 1'b1, 1'b0);
    v = {16'sd4, -16'sd20, 16'sd30, 16'sd1};
    scan(4, v, 1'b0, 1'b1);

    // Reset in the third scan cycle wipes everything and never yields done.
    for (int i = 0; i < 4; i++) mem4[i] = 16'sd100 + 16'(i);
    drive(4, 1'b1, 1'b0);
    tick(); drive(4, 1'b0, 1'b0);
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst sel", sel4, 0);   check("midrst busy", busy4, 0);
    check("midrst done", done4, 0); check("midrst q", q_best4, 0);
    check("midrst act", act4, 0);
    prev_q[0] = '0; prev_a[0] = 0;
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("postrst done", done4, 0);
      check("postrst busy", busy4, 0);
    end
    v = {-16'sd7, 16'sd3, 16'sd3, -16'sd9};
    scan(4, v, 1'b0, 1'b0);

    v = {-16'sd1, -16'sd2, -16'sd8, 16'sd100, 16'sd100, -16'sd100, 16'sd3, 16'sd0};
    scan(8, v, 1'b0, 1'b0);
    scan(8, v, 1'b1, 1'b0);

    for (int r = 0; r < 16; r++) begin
      int w = (r % 2 == 0) ? 4 : 8;
      int n = (w == 8) ? 8 : 4;
      v = {};
      for (int i = 0; i < n; i++) begin
        logic signed [15:0] x;
        x = 16'($urandom);
        if (i > 0 && $urandom_range(0, 3) == 0) x = v[$urandom_range(0, i - 1)];
        else if ($urandom_range(0, 7) == 0) x = 16'sh8000;
        v.push_back(x);
      end
      scan(w, v, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/q_argmax_scanner.md
Name: q_argmax_scanner

Overview:
- Sequential front-end for the Q-table read path. Steps the select input of an external mux4to1/mux8to1 across all action Q-values of the current state.
- Compares the returned values one per cycle and reports the maximum Q-value and its action index, or the minimum when requested.
- Feeds the agent's action-selection and Q-update (max Q of next state) logic.

Parameters:
- DATA_WIDTH, 16, width of each Q-value (signed two's-complement fixed point).
- N_ACTION, 4, number of actions scanned; legal values 2..2^SEL_WIDTH.
- SEL_WIDTH, 2, width of mux select and action index (2 for mux4to1, 3 for mux8to1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- find_min  input  1  sampled with start: 0 = argmax, 1 = argmin; held internally for the scan.
- sel  output  SEL_WIDTH  mux select; drives sel of the external mux.
- q_in  input  DATA_WIDTH  mux out0; combinational response to sel in the same cycle.
- busy  output  1  high from the cycle after start until done is asserted.
- done  output  1  one-cycle pulse; q_best and act_best are valid from this cycle.
- q_best  output  DATA_WIDTH  winning Q-value, signed; held until the next scan completes.
- act_best  output  SEL_WIDTH  index of the winning action; held until the next scan completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - sel=0, busy=0, done=0, q_best=0, act_best=0, find_min latch=0.
  - Applies immediately, including mid-scan; partial results are discarded and no done is issued.
- States: IDLE, SCAN, DONE.
- IDLE:
  - sel held at 0, busy=0.
  - start=1 latches find_min, clears the scan counter, moves to SCAN.
- SCAN, one action per cycle, with q_in sampled against the current sel:
  - When sel==0: running best = q_in and running index = 0 (unconditional load).
  - When sel>0: update if q_in > best (find_min=0) or q_in < best (find_min=1). Comparison is signed and strict, so ties keep the lower index.
  - sel increments by 1 each cycle.
  - After sampling sel==N_ACTION-1: load q_best/act_best with the final result, sel returns to 0, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start in this cycle is ignored.
- Latency:
  - start in cycle T gives SCAN in cycles T+1..T+N_ACTION.
  - done in cycle T+N_ACTION+1.
  - Back-to-back scans are possible with start at T+N_ACTION+2.
- start asserted during SCAN/DONE: ignored (not queued); find_min is not re-latched.
- Output update rules:
  - q_best/act_best change only on entry to DONE.
  - They never expose intermediate running values.
- sel never exceeds N_ACTION-1, so unused mux inputs are never selected.
- No arithmetic beyond comparison and increment; the counter is SEL_WIDTH bits and does not wrap inside a scan.
- Most-negative value (0x8000 for 16 bits) is handled as a legal operand.

Decomposition:
- Shared package/header:
  - State encoding constants ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
  - Default DATA_WIDTH/N_ACTION/SEL_WIDTH values, common with the mux and Q-table blocks.
- One natural sub-module: q_compare_update. It is the combinational signed compare (greater or less by find_min) producing take_new, and is reused later by the epsilon-greedy selector.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then start=1, find_min=0, mux inputs {10, -3, 250, 7} -> sel 0,1,2,3 on cycles T+1..T+4; done at T+5; q_best=250, act_best=2; busy high T+1..T+4.
- Same inputs with find_min=1 -> q_best=-3 (0xFFFD), act_best=1.
- Ties: inputs {5, 9, 9, 9} with argmax -> act_best=1. Inputs {0x8000, 0x8000, 0, 1} with argmin -> q_best=0x8000, act_best=0.
- start re-asserted during SCAN and in the DONE cycle -> no extra scan, no extra done pulse; results unchanged.
- rst_n pulsed low during the third SCAN cycle -> outputs zero immediately, state IDLE, no done. A following start performs a full correct scan.
- N_ACTION=8, SEL_WIDTH=3 with mux8to1, inputs {-1, -2, -8, 100, 100, -100, 3, 0} -> argmax gives 100/act 3; argmin gives -100/act 5; done at T+9.
